pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It drives the pause and bubble controls of the PC, IF/ID (ii), ID/EXE (ie), EXE/MEM (em) and MEM/WB (mw) registers. It resolves three hazards:
- load-use data hazards between ID and EXE
- taken jumps resolved in EXE
- the structural conflict on the single shared SRAM between instruction fetch and MEM-stage data access, which may last several cycles.

---
 rtl/pipe_hazard_ctrl.sv | 86 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush control for load-use, EXE jumps and the shared-SRAM fetch/MEM conflict
// Optional PIPE_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module pipe_hazard_ctrl #(
   parameter int REG_AW   = 4,
   parameter int RAM_WAIT = 2
) (
   input  logic              clk_50MHz,
   input  logic              rst,
   input  logic              id_use_a,
   input  logic [REG_AW-1:0] id_src_a,
   input  logic              id_use_b,
   input  logic [REG_AW-1:0] id_src_b,
   input  logic              ie_load,
   input  logic              ie_dst_vld,
   input  logic [REG_AW-1:0] ie_dst,
   input  logic              ie_jump,
   input  logic              mem_req,
   output logic              pc_PAUSE,
   output logic              ii_PAUSE,
   output logic              ie_PAUSE,
   output logic              em_PAUSE,
   output logic              ii_FLUSH,
   output logic              ie_FLUSH,
   output logic              mw_FLUSH,
   output logic              ctrl_busy
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt
`endif
);
   typedef enum logic {S_RUN, S_MEM} state_t;
   localparam bit MULTI = RAM_WAIT > 1;
   state_t state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic lu, freeze, rel, run;
   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         state <= S_RUN;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (state == S_MEM) begin
         state_nxt = (cnt == 3'd1) ? S_RUN : S_MEM;
         cnt_nxt   = cnt - 3'd1;
      end else if (mem_req && MULTI) begin
         state_nxt = S_MEM;
         cnt_nxt   = 3'(RAM_WAIT - 1);
      end
   end
   assign lu = ie_load & ie_dst_vld &
               ((id_use_a & (id_src_a == ie_dst)) | (id_use_b & (id_src_b == ie_dst)));
   // freeze/release are the two phases of an SRAM access; run is the free-flowing case
   assign freeze = !rst && ((state == S_MEM) ? (cnt != 3'd1) : (mem_req && MULTI));
   assign rel    = !rst && ((state == S_MEM) ? (cnt == 3'd1) : (mem_req && !MULTI));
   assign run    = !rst && (state == S_RUN) && !mem_req;
   always_comb begin
      pc_PAUSE  = freeze | (rel & ~ie_jump) | (run & ~ie_jump & lu);
      ii_PAUSE  = freeze | ((rel | run) & ~ie_jump & lu);
      ie_PAUSE  = freeze;
      em_PAUSE  = freeze;
      ii_FLUSH  = rst | (rel & (ie_jump | ~lu)) | (run & ie_jump);
      ie_FLUSH  = rst | ((rel | run) & (ie_jump | lu));
      mw_FLUSH  = rst | freeze;
      ctrl_busy = !rst && (state == S_MEM);
   end
`ifdef PIPE_PERF_CNT_EN
   logic jflush;
   assign jflush = (rel | run) & ie_jump;
   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
      end else begin
         if (pc_PAUSE && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
         if (jflush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector bench over four RAM_WAIT variants sharing one input bus.
// Outputs are packed {pc,ii,ie,em PAUSE, ii,ie,mw FLUSH, ctrl_busy}.
module tb_pipe_hazard_ctrl;
   logic clk_50MHz = 1'b0;
   logic rst = 1'b1;
   logic id_use_a = 1'b0, id_use_b = 1'b0, ie_load = 1'b0, ie_dst_vld = 1'b0;
   logic ie_jump = 1'b0, mem_req = 1'b0;
   logic [3:0] id_src_a = 4'h0, id_src_b = 4'h0, ie_dst = 4'h0;
   logic [7:0] o1, o3, o4, o5;
   int n_run = 0, n_fail = 0;
`ifdef PIPE_PERF_CNT_EN
   logic [15:0] sc1, fc1, sc3, fc3, sc4, fc4, sc5, fc5;
`endif
   always #10 clk_50MHz = ~clk_50MHz;

   pipe_hazard_ctrl #(.REG_AW(4), .RAM_WAIT(1)) w1 (
      .clk_50MHz(clk_50MHz), .rst(rst), .id_use_a(id_use_a), .id_src_a(id_src_a),
      .id_use_b(id_use_b), .id_src_b(id_src_b), .ie_load(ie_load), .ie_dst_vld(ie_dst_vld),
      .ie_dst(ie_dst), .ie_jump(ie_jump), .mem_req(mem_req),
      .pc_PAUSE(o1[7]), .ii_PAUSE(o1[6]), .ie_PAUSE(o1[5]), .em_PAUSE(o1[4]),
      .ii_FLUSH(o1[3]), .ie_FLUSH(o1[2]), .mw_FLUSH(o1[1]), .ctrl_busy(o1[0])
`ifdef PIPE_PERF_CNT_EN
      , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
   );
   pipe_hazard_ctrl #(.REG_AW(4), .RAM_WAIT(3)) w3 (
      .clk_50MHz(clk_50MHz), .rst(rst), .id_use_a(id_use_a), .id_src_a(id_src_a),
      .id_use_b(id_use_b), .id_src_b(id_src_b), .ie_load(ie_load), .ie_dst_vld(ie_dst_vld),
      .ie_dst(ie_dst), .ie_jump(ie_jump), .mem_req(mem_req),
      .pc_PAUSE(o3[7]), .ii_PAUSE(o3[6]), .ie_PAUSE(o3[5]), .em_PAUSE(o3[4]),
      .ii_FLUSH(o3[3]), .ie_FLUSH(o3[2]), .mw_FLUSH(o3[1]), .ctrl_busy(o3[0])
`ifdef PIPE_PERF_CNT_EN
      , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
   );
   pipe_hazard_ctrl #(.REG_AW(4), .RAM_WAIT(4)) w4 (
      .clk_50MHz(clk_50MHz), .rst(rst), .id_use_a(id_use_a), .id_src_a(id_src_a),
      .id_use_b(id_use_b), .id_src_b(id_src_b), .ie_load(ie_load), .ie_dst_vld(ie_dst_vld),
      .ie_dst(ie_dst), .ie_jump(ie_jump), .mem_req(mem_req),
      .pc_PAUSE(o4[7]), .ii_PAUSE(o4[6]), .ie_PAUSE(o4[5]), .em_PAUSE(o4[4]),
      .ii_FLUSH(o4[3]), .ie_FLUSH(o4[2]), .mw_FLUSH(o4[1]), .ctrl_busy(o4[0])
`ifdef PIPE_PERF_CNT_EN
      , .stall_cnt(sc4), .flush_cnt(fc4)
`endif
   );
   pipe_hazard_ctrl #(.REG_AW(4), .RAM_WAIT(5)) w5 (
      .clk_50MHz(clk_50MHz), .rst(rst), .id_use_a(id_use_a), .id_src_a(id_src_a),
      .id_use_b(id_use_b), .id_src_b(id_src_b), .ie_load(ie_load), .ie_dst_vld(ie_dst_vld),
      .ie_dst(ie_dst), .ie_jump(ie_jump), .mem_req(mem_req),
      .pc_PAUSE(o5[7]), .ii_PAUSE(o5[6]), .ie_PAUSE(o5[5]), .em_PAUSE(o5[4]),
      .ii_FLUSH(o5[3]), .ie_FLUSH(o5[2]), .mw_FLUSH(o5[1]), .ctrl_busy(o5[0])
`ifdef PIPE_PERF_CNT_EN
      , .stall_cnt(sc5), .flush_cnt(fc5)
`endif
   );

   typedef struct {
      logic rst, mem, jmp, ld, ua;
      logic [3:0] sa;
      logic ub;
      logic [3:0] sb, dst;
      logic [7:0] e3, e1;
   } vec_t;
   vec_t tbl[19];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // apply on the falling edge, settle, then leave the rising edge to the DUT
   task automatic cyc(input vec_t v);
      @(negedge clk_50MHz);
      rst = v.rst; mem_req = v.mem; ie_jump = v.jmp;
      ie_load = v.ld; ie_dst_vld = v.ld; ie_dst = v.dst;
      id_use_a = v.ua; id_src_a = v.sa; id_use_b = v.ub; id_src_b = v.sb;
      #5;
   endtask

   task automatic step(input logic r, input logic m, input logic j);
      vec_t v;
      v = '{r, m, j, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00};
      cyc(v);
   endtask

   initial begin
      // rst, mem, jmp, ld, ua, sa, ub, sb, dst, exp(RAM_WAIT=3), exp(RAM_WAIT=1)
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 8'h0E, 8'h0E};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 8'h0E, 8'h0E};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h3, 4'h3, 8'hC4, 8'hC4};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h2, 4'h3, 8'h00, 8'h00};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 4'h0, 4'h5, 8'hC4, 8'hC4};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 8'h0C, 8'h0C};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h3, 4'h3, 8'h0C, 8'h0C};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 8'hF2, 8'h88};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 8'hF3, 8'h88};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 8'h89, 8'h88};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 8'hF2, 8'h88};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 8'hF3, 8'h00};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h3, 4'h3, 8'hC5, 8'hC4};
      tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h3, 4'h3, 8'hF2, 8'h0C};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 8'hF3, 8'h00};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 8'h0D, 8'h0C};
      tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00};
      for (int i = 0; i < 19; i++) begin
         cyc(tbl[i]);
         chk($sformatf("vec%0d w3", i), {8'h00, o3}, {8'h00, tbl[i].e3});
         chk($sformatf("vec%0d w1", i), {8'h00, o1}, {8'h00, tbl[i].e1});
      end
      // jump held through a 4-cycle access
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1); chk("w4 jmp c1", {8'h00, o4}, 16'h00F2);
      step(1'b0, 1'b0, 1'b1); chk("w4 jmp c2", {8'h00, o4}, 16'h00F3);
      step(1'b0, 1'b0, 1'b1); chk("w4 jmp c3", {8'h00, o4}, 16'h00F3);
      step(1'b0, 1'b0, 1'b1); chk("w4 jmp c4", {8'h00, o4}, 16'h000D);
      step(1'b0, 1'b0, 1'b0); chk("w4 jmp c5", {8'h00, o4}, 16'h0000);
`ifdef PIPE_PERF_CNT_EN
      chk("w4 stall_cnt", sc4, 16'd3);
      chk("w4 flush_cnt", fc4, 16'd1);
`endif
      // reset abandons a 5-cycle access in its second freeze cycle
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0); chk("w5 rst c1", {8'h00, o5}, 16'h00F2);
      step(1'b1, 1'b0, 1'b0); chk("w5 rst c2", {8'h00, o5}, 16'h000E);
      step(1'b0, 1'b0, 1'b0); chk("w5 rst c3", {8'h00, o5}, 16'h0000);
`ifdef PIPE_PERF_CNT_EN
      chk("w5 stall_cnt", sc5, 16'd0);
`endif
      step(1'b0, 1'b0, 1'b0); chk("w5 rst c4", {8'h00, o5}, 16'h0000);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
